// File: rtl/aes_stim_sequencer.sv
// ---------------------------------------------------------------------------
// aes_stim_sequencer
//
// On-chip stimulus sequencer for AES_top trace/dump campaigns. A run plays
// num_blocks blocks. For each block the sequencer loads a plaintext, holds
// aes_en high for a fixed window, captures the first ciphertext returned and
// then idles for a fixed gap. Plaintext sources: fixed, table, LFSR, or
// fixed/LFSR interleave.
//
// Ports
//   AES_clk, AES_rst      clock (rising edge), async active-high reset
//   start                 1-cycle run request, only accepted in IDLE
//   mode                  0 fixed, 1 table, 2 LFSR, 3 fixed/LFSR interleave
//   num_blocks            blocks per run (0 gives an immediate done)
//   fixed_data, key_in    plaintext for modes 0/3; key latched at start
//   tbl_wr_*              plaintext table write port (usable during a run)
//   aes_en, aes_data_in,
//   aes_key_in            drive AES_top
//   aes_data_out_valid,
//   aes_data_out          ciphertext returned by AES_top
//   trig                  scope trigger, same as aes_en
//   busy, done            run in progress / 1-cycle end-of-run pulse
//   timeout_err           sticky, some block never returned a ciphertext
//   blk_cnt               blocks completed in this run
//   last_ct, ct_xor       last ciphertext and XOR signature of the run
// ---------------------------------------------------------------------------
module aes_stim_sequencer #(
  parameter int unsigned       DATA_W     = 128,
  parameter int unsigned       NUM_VEC    = 4,
  parameter int unsigned       EN_CYCLES  = 51,
  parameter int unsigned       GAP_CYCLES = 15,
  parameter int unsigned       TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] LFSR_SEED  = {{(DATA_W-1){1'b0}}, 1'b1}
) (
  input  logic                       AES_clk,
  input  logic                       AES_rst,
  input  logic                       start,
  input  logic [1:0]                 mode,
  input  logic [15:0]                num_blocks,
  input  logic [DATA_W-1:0]          fixed_data,
  input  logic [DATA_W-1:0]          key_in,
  input  logic                       tbl_wr_en,
  input  logic [$clog2(NUM_VEC)-1:0] tbl_wr_addr,
  input  logic [DATA_W-1:0]          tbl_wr_data,
  output logic                       aes_en,
  output logic [DATA_W-1:0]          aes_data_in,
  output logic [DATA_W-1:0]          aes_key_in,
  input  logic                       aes_data_out_valid,
  input  logic [DATA_W-1:0]          aes_data_out,
  output logic                       trig,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic [15:0]                blk_cnt,
  output logic [DATA_W-1:0]          last_ct,
  output logic [DATA_W-1:0]          ct_xor
);

  localparam int unsigned IDX_W   = $clog2(NUM_VEC);
  localparam int unsigned CNT_MAX =
    (EN_CYCLES > GAP_CYCLES) ? ((EN_CYCLES > TIMEOUT) ? EN_CYCLES : TIMEOUT)
                             : ((GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  // Feedback taps for x^128 + x^7 + x^2 + x + 1 in left-shifting Galois form.
  localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'h87);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENABLE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [15:0]         num_blocks_q, num_blocks_d;
  logic [15:0]         blk_cnt_q, blk_cnt_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   lfsr_q, lfsr_d;
  logic [DATA_W-1:0]   last_ct_q, last_ct_d;
  logic [DATA_W-1:0]   ct_xor_q, ct_xor_d;
  logic                timeout_err_q, timeout_err_d;
  logic                captured_q, captured_d;

  logic [DATA_W-1:0]   tbl_q [NUM_VEC];
  logic [DATA_W-1:0]   lfsr_next;
  logic                capture_now;

  // The table has no reset so its contents survive AES_rst between campaigns.
  always_ff @(posedge AES_clk) begin
    if (tbl_wr_en) begin
      tbl_q[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  assign lfsr_next = {lfsr_q[DATA_W-2:0], 1'b0} ^
                     (lfsr_q[DATA_W-1] ? LFSR_TAPS : '0);

  // Only the first valid of a block is taken; captured_q masks the rest.
  assign capture_now = ((state_q == S_ENABLE) || (state_q == S_WAIT)) &&
                       aes_data_out_valid && !captured_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    num_blocks_d  = num_blocks_q;
    blk_cnt_d     = blk_cnt_q;
    key_d         = key_q;
    data_d        = data_q;
    lfsr_d        = lfsr_q;
    last_ct_d     = last_ct_q;
    ct_xor_d      = ct_xor_q;
    timeout_err_d = timeout_err_q;
    captured_d    = captured_q;

    if (capture_now) begin
      last_ct_d  = aes_data_out;
      ct_xor_d   = ct_xor_q ^ aes_data_out;
      captured_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d        = mode;
          num_blocks_d  = num_blocks;
          key_d         = key_in;
          blk_cnt_d     = '0;
          ct_xor_d      = '0;
          timeout_err_d = 1'b0;
          state_d       = (num_blocks == 16'd0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        captured_d = 1'b0;
        cnt_d      = '0;
        state_d    = S_ENABLE;
        unique case (mode_q)
          2'd0: data_d = fixed_data;
          2'd1: data_d = tbl_q[blk_cnt_q[IDX_W-1:0]];
          2'd2: begin
            data_d = lfsr_q;
            lfsr_d = lfsr_next;
          end
          default: begin
            // Odd blocks take the LFSR, even blocks the fixed plaintext.
            if (blk_cnt_q[0]) begin
              data_d = lfsr_q;
              lfsr_d = lfsr_next;
            end else begin
              data_d = fixed_data;
            end
          end
        endcase
      end

      S_ENABLE: begin
        if (cnt_q == EN_LAST) begin
          cnt_d = '0;
          if (captured_q || capture_now) begin
            state_d   = S_GAP;
            blk_cnt_d = blk_cnt_q + 16'd1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT: begin
        if (capture_now) begin
          cnt_d     = '0;
          state_d   = S_GAP;
          blk_cnt_d = blk_cnt_q + 16'd1;
        end else if (cnt_q == TO_LAST) begin
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = S_GAP;
          blk_cnt_d     = blk_cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = (blk_cnt_q == num_blocks_q) ? S_DONE : S_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mode_q        <= '0;
      num_blocks_q  <= '0;
      blk_cnt_q     <= '0;
      key_q         <= '0;
      data_q        <= '0;
      lfsr_q        <= LFSR_SEED;
      last_ct_q     <= '0;
      ct_xor_q      <= '0;
      timeout_err_q <= 1'b0;
      captured_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      num_blocks_q  <= num_blocks_d;
      blk_cnt_q     <= blk_cnt_d;
      key_q         <= key_d;
      data_q        <= data_d;
      lfsr_q        <= lfsr_d;
      last_ct_q     <= last_ct_d;
      ct_xor_q      <= ct_xor_d;
      timeout_err_q <= timeout_err_d;
      captured_q    <= captured_d;
    end
  end

  assign aes_en      = (state_q == S_ENABLE);
  assign trig        = aes_en;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign aes_data_in = data_q;
  assign aes_key_in  = key_q;
  assign timeout_err = timeout_err_q;
  assign blk_cnt     = blk_cnt_q;
  assign last_ct     = last_ct_q;
  assign ct_xor      = ct_xor_q;

endmodule

// File: tb/tb_aes_stim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_stim_sequencer
//
// Directed bench for aes_stim_sequencer. A stub stands in for AES_top: a
// fixed number of cycles after aes_en rises it returns data_in ^ key, then
// one more (garbage) valid that the sequencer must ignore. With an even
// number of blocks the key cancels in ct_xor, so signatures reduce to
// simple hand-derived constants.
// ---------------------------------------------------------------------------
module tb_aes_stim_sequencer;

  localparam logic [127:0] KEY0 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] FIX0 = 128'h0000006b_00000000_00000000_00000000;
  localparam logic [127:0] CT0  = 128'haa2bdb2b_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] FIX3 = 128'h01234567_89abcdef_fedcba98_76543210;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [15:0]  num_blocks = 16'd0;
  logic [127:0] fixed_data = '0;
  logic [127:0] key_in = '0;
  logic         tbl_wr_en = 1'b0;
  logic [1:0]   tbl_wr_addr = 2'd0;
  logic [127:0] tbl_wr_data = '0;
  logic         aes_en;
  logic [127:0] aes_data_in;
  logic [127:0] aes_key_in;
  logic         aes_data_out_valid = 1'b0;
  logic [127:0] aes_data_out = '0;
  logic         trig;
  logic         busy;
  logic         done;
  logic         timeout_err;
  logic [15:0]  blk_cnt;
  logic [127:0] last_ct;
  logic [127:0] ct_xor;

  aes_stim_sequencer #(
    .DATA_W     (128),
    .NUM_VEC    (4),
    .EN_CYCLES  (51),
    .GAP_CYCLES (15),
    .TIMEOUT    (255),
    .LFSR_SEED  (128'h1)
  ) dut (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .start              (start),
    .mode               (mode),
    .num_blocks         (num_blocks),
    .fixed_data         (fixed_data),
    .key_in             (key_in),
    .tbl_wr_en          (tbl_wr_en),
    .tbl_wr_addr        (tbl_wr_addr),
    .tbl_wr_data        (tbl_wr_data),
    .aes_en             (aes_en),
    .aes_data_in        (aes_data_in),
    .aes_key_in         (aes_key_in),
    .aes_data_out_valid (aes_data_out_valid),
    .aes_data_out       (aes_data_out),
    .trig               (trig),
    .busy               (busy),
    .done               (done),
    .timeout_err        (timeout_err),
    .blk_cnt            (blk_cnt),
    .last_ct            (last_ct),
    .ct_xor             (ct_xor)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int en_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [127:0] data_log [$];
  int snap_en, snap_done, snap_busy, snap_log;

  bit   stub_on = 1'b1;
  int   stub_lat = 10;
  bit   armed = 1'b0;
  int   age = 0;
  logic prev_en = 1'b0;

  logic [127:0] tvec [4];

  // Stub AES and activity monitor, evaluated on the falling edge so DUT
  // outputs are settled and stub responses are ready for the next rising edge.
  always @(negedge clk) begin
    aes_data_out_valid = 1'b0;
    aes_data_out       = '0;
    if (aes_en && !prev_en) begin
      data_log.push_back(aes_data_in);
      armed = 1'b1;
      age   = 0;
    end else if (armed) begin
      age = age + 1;
    end
    if (armed && stub_on && age == stub_lat) begin
      aes_data_out_valid = 1'b1;
      aes_data_out       = aes_data_in ^ aes_key_in;
    end else if (armed && stub_on && age == stub_lat + 1) begin
      aes_data_out_valid = 1'b1;
      aes_data_out       = ~(aes_data_in ^ aes_key_in);
    end
    if (age > stub_lat) armed = 1'b0;
    if (aes_en) en_cnt = en_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    prev_en = aes_en;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] act,
                             input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] nb);
    tick();
    snap_en    = en_cnt;
    snap_done  = done_cnt;
    snap_busy  = busy_cnt;
    snap_log   = data_log.size();
    mode       = m;
    num_blocks = nb;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles);
    int n;
    n = 0;
    while (done_cnt == snap_done && n < max_cycles) begin
      tick();
      n = n + 1;
    end
    checkOutput("done_seen", 128'(done_cnt != snap_done), 128'd1);
    repeat (3) tick();
  endtask

  task automatic writeTable(input logic [1:0] addr, input logic [127:0] d);
    tick();
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = addr;
    tbl_wr_data = d;
    tick();
    tbl_wr_en   = 1'b0;
  endtask

  initial begin
    tvec[0] = 128'ha6f2daeb_11111111_22222222_33333333;
    tvec[1] = 128'hd7b26248_44444444_55555555_66666666;
    tvec[2] = 128'hf301a68a_77777777_88888888_99999999;
    tvec[3] = 128'h0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_done", 128'(done), 128'd0);
    checkOutput("rst_aes_en", 128'(aes_en), 128'd0);
    checkOutput("rst_blk_cnt", 128'(blk_cnt), 128'd0);
    checkOutput("rst_last_ct", last_ct, 128'd0);
    checkOutput("rst_ct_xor", ct_xor, 128'd0);
    checkOutput("rst_timeout", 128'(timeout_err), 128'd0);
    checkOutput("rst_data_in", aes_data_in, 128'd0);

    // Mode 0, one block, plus an ignored start while busy
    key_in     = KEY0;
    fixed_data = FIX0;
    stub_lat   = 10;
    applyStimulus(2'd0, 16'd1);
    checkOutput("m0_load_en", 128'(aes_en), 128'd0);
    checkOutput("m0_load_busy", 128'(busy), 128'd1);
    tick();
    checkOutput("m0_en_rise", 128'(aes_en), 128'd1);
    checkOutput("m0_trig", 128'(trig), 128'd1);
    checkOutput("m0_data_in", aes_data_in, FIX0);
    checkOutput("m0_key_in", aes_key_in, KEY0);
    repeat (5) tick();
    mode       = 2'd2;
    num_blocks = 16'd5;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    waitDone(300);
    checkOutput("m0_en_cycles", 128'(en_cnt - snap_en), 128'd51);
    checkOutput("m0_done_cnt", 128'(done_cnt - snap_done), 128'd1);
    checkOutput("m0_busy_cycles", 128'(busy_cnt - snap_busy), 128'd68);
    checkOutput("m0_blk_cnt", 128'(blk_cnt), 128'd1);
    checkOutput("m0_last_ct", last_ct, CT0);
    checkOutput("m0_ct_xor", ct_xor, CT0);
    checkOutput("m0_data_held", aes_data_in, FIX0);

    // Mode 1, table source with wrap
    for (int i = 0; i < 4; i++) writeTable(2'(i), tvec[i]);
    applyStimulus(2'd1, 16'd6);
    waitDone(700);
    checkOutput("m1_blocks_seen", 128'(data_log.size() - snap_log), 128'd6);
    for (int i = 0; i < 6; i++) begin
      if (snap_log + i < data_log.size())
        checkOutput($sformatf("m1_data%0d", i), data_log[snap_log + i], tvec[i % 4]);
    end
    checkOutput("m1_ct_xor", ct_xor, tvec[2]);
    checkOutput("m1_last_ct", last_ct, tvec[1] ^ KEY0);
    checkOutput("m1_blk_cnt", 128'(blk_cnt), 128'd6);
    checkOutput("m1_en_cycles", 128'(en_cnt - snap_en), 128'd306);

    // Timeout: AES never answers
    stub_on = 1'b0;
    applyStimulus(2'd0, 16'd2);
    waitDone(900);
    checkOutput("to_err", 128'(timeout_err), 128'd1);
    checkOutput("to_blk_cnt", 128'(blk_cnt), 128'd2);
    checkOutput("to_ct_xor", ct_xor, 128'd0);
    checkOutput("to_last_ct_kept", last_ct, tvec[1] ^ KEY0);
    checkOutput("to_busy_cycles", 128'(busy_cnt - snap_busy), 128'd645);
    checkOutput("to_done_cnt", 128'(done_cnt - snap_done), 128'd1);

    // Mode 3 interleave, ciphertext arrives in WAIT
    stub_on    = 1'b1;
    stub_lat   = 60;
    fixed_data = FIX3;
    applyStimulus(2'd3, 16'd4);
    checkOutput("m3_err_cleared", 128'(timeout_err), 128'd0);
    waitDone(800);
    checkOutput("m3_blocks_seen", 128'(data_log.size() - snap_log), 128'd4);
    if (data_log.size() >= snap_log + 4) begin
      checkOutput("m3_data0", data_log[snap_log + 0], FIX3);
      checkOutput("m3_data1", data_log[snap_log + 1], 128'h1);
      checkOutput("m3_data2", data_log[snap_log + 2], FIX3);
      checkOutput("m3_data3", data_log[snap_log + 3], 128'h2);
    end
    checkOutput("m3_ct_xor", ct_xor, 128'h3);
    checkOutput("m3_last_ct", last_ct, 128'h2 ^ KEY0);
    checkOutput("m3_blk_cnt", 128'(blk_cnt), 128'd4);
    checkOutput("m3_timeout", 128'(timeout_err), 128'd0);

    // num_blocks = 0: done right after start, no enable
    stub_lat = 10;
    applyStimulus(2'd0, 16'd0);
    checkOutput("nb0_done", 128'(done), 128'd1);
    checkOutput("nb0_busy", 128'(busy), 128'd1);
    checkOutput("nb0_aes_en", 128'(aes_en), 128'd0);
    tick();
    checkOutput("nb0_done_drop", 128'(done), 128'd0);
    checkOutput("nb0_busy_drop", 128'(busy), 128'd0);
    checkOutput("nb0_en_cycles", 128'(en_cnt - snap_en), 128'd0);
    checkOutput("nb0_data_held", aes_data_in, 128'h2);

    // Reset during the second block's enable window
    applyStimulus(2'd2, 16'd3);
    begin
      int n;
      n = 0;
      while (!(blk_cnt == 16'd1 && aes_en) && n < 300) begin
        tick();
        n = n + 1;
      end
      checkOutput("mid_reach_blk1", 128'(blk_cnt == 16'd1 && aes_en), 128'd1);
    end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_aes_en", 128'(aes_en), 128'd0);
    checkOutput("mid_rst_busy", 128'(busy), 128'd0);
    checkOutput("mid_rst_blk_cnt", 128'(blk_cnt), 128'd0);
    checkOutput("mid_rst_ct_xor", ct_xor, 128'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    checkOutput("mid_rst_no_done", 128'(done_cnt - snap_done), 128'd0);

    // Fresh run after reset: LFSR restarts at its seed
    applyStimulus(2'd2, 16'd2);
    waitDone(400);
    if (data_log.size() >= snap_log + 2) begin
      checkOutput("post_data0", data_log[snap_log + 0], 128'h1);
      checkOutput("post_data1", data_log[snap_log + 1], 128'h2);
    end
    checkOutput("post_ct_xor", ct_xor, 128'h3);
    checkOutput("post_last_ct", last_ct, 128'h2 ^ KEY0);
    checkOutput("post_blk_cnt", 128'(blk_cnt), 128'd2);
    checkOutput("post_done_cnt", 128'(done_cnt - snap_done), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no end of test expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
